// File: rtl/window_rot_mux.sv
// Registered K x K window rotation mux between the register array and the OPU.
// The row/column shifts come from static configuration or from an auto-sweep over all alignments.
module window_rot_mux #(
    parameter int  DW = 128,
    parameter int  K  = 3,
    localparam int SW = $clog2(K)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CFG_AUTO,
    input  logic [SW-1:0]     CFG_ROW_SHIFT,
    input  logic [SW-1:0]     CFG_COL_SHIFT,
    input  logic              CFG_LOAD,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DW*K*K-1:0] REG_ARRAY,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DW*K*K-1:0] MUX2OPU,
    output logic [SW-1:0]     OUT_ROW_SHIFT,
    output logic [SW-1:0]     OUT_COL_SHIFT,
    output logic              OUT_LAST
);

    localparam logic [SW:0]   K_L   = (SW+1)'(K);
    localparam logic [SW-1:0] K_MAX = SW'(K-1);

    // Shift values that cannot address a row/column (K not a power of 2) act as zero.
    function automatic logic [SW-1:0] clamp_shift(input logic [SW-1:0] v);
        logic [SW-1:0] res;
        if ({1'b0, v} >= K_L) begin
            res = {SW{1'b0}};
        end else begin
            res = v;
        end
        return res;
    endfunction

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] pos, input logic [SW-1:0] sh);
        logic [SW:0] sum;
        sum = {1'b0, pos} + {1'b0, sh};
        if (sum >= K_L) begin
            sum = sum - K_L;
        end else begin
            sum = sum;
        end
        return sum[SW-1:0];
    endfunction

    logic              accept_s;
    logic [SW-1:0]     rs_eff_s;
    logic [SW-1:0]     cs_eff_s;
    logic              last_s;
    logic [SW-1:0]     row_nxt_s;
    logic [SW-1:0]     col_nxt_s;
    logic [DW*K*K-1:0] rot_data_s;
    logic [DW-1:0]     in_elem_s [K][K];

    logic [SW-1:0]     row_cnt_r;
    logic [SW-1:0]     col_cnt_r;
    logic              out_valid_r;
    logic [DW*K*K-1:0] data_r;
    logic [SW-1:0]     out_rs_r;
    logic [SW-1:0]     out_cs_r;
    logic              last_r;

    assign accept_s = IN_VALID & IN_READY;
    assign IN_READY = ~out_valid_r | OUT_READY;

    // Element 0 sits at the MSB end of the packed window.
    for (genvar gr = 0; gr < K; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            logic [SW-1:0] src_r_s;
            logic [SW-1:0] src_c_s;
            assign in_elem_s[gr][gc] = REG_ARRAY[DW*(K*K-(gr*K+gc))-1 -: DW];
            assign src_r_s = wrap_add(SW'(gr), rs_eff_s);
            assign src_c_s = wrap_add(SW'(gc), cs_eff_s);
            assign rot_data_s[DW*(K*K-(gr*K+gc))-1 -: DW] = in_elem_s[src_r_s][src_c_s];
        end
    end

    // Effective shifts and the last-alignment flag for the beat being accepted.
    always_comb begin
        rs_eff_s = {SW{1'b0}};
        cs_eff_s = {SW{1'b0}};
        last_s   = 1'b0;
        if (CFG_AUTO) begin
            rs_eff_s = row_cnt_r;
            cs_eff_s = col_cnt_r;
            last_s   = (row_cnt_r == K_MAX) && (col_cnt_r == K_MAX);
        end else begin
            rs_eff_s = clamp_shift(CFG_ROW_SHIFT);
            cs_eff_s = clamp_shift(CFG_COL_SHIFT);
            last_s   = 1'b0;
        end
    end

    // Sequencer next state: a load overrides the increment of an auto accept.
    always_comb begin
        row_nxt_s = row_cnt_r;
        col_nxt_s = col_cnt_r;
        if (CFG_LOAD) begin
            row_nxt_s = clamp_shift(CFG_ROW_SHIFT);
            col_nxt_s = clamp_shift(CFG_COL_SHIFT);
        end else if (accept_s && CFG_AUTO) begin
            if (col_cnt_r == K_MAX) begin
                col_nxt_s = {SW{1'b0}};
                if (row_cnt_r == K_MAX) begin
                    row_nxt_s = {SW{1'b0}};
                end else begin
                    row_nxt_s = row_cnt_r + 1'b1;
                end
            end else begin
                col_nxt_s = col_cnt_r + 1'b1;
            end
        end else begin
            row_nxt_s = row_cnt_r;
            col_nxt_s = col_cnt_r;
        end
    end

    // Output stage and sequencer counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_r <= 1'b0;
            data_r      <= {(DW*K*K){1'b0}};
            out_rs_r    <= {SW{1'b0}};
            out_cs_r    <= {SW{1'b0}};
            last_r      <= 1'b0;
            row_cnt_r   <= {SW{1'b0}};
            col_cnt_r   <= {SW{1'b0}};
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                data_r      <= rot_data_s;
                out_rs_r    <= rs_eff_s;
                out_cs_r    <= cs_eff_s;
                last_r      <= last_s;
            end else if (OUT_READY) begin
                out_valid_r <= 1'b0;
            end
            row_cnt_r <= row_nxt_s;
            col_cnt_r <= col_nxt_s;
        end
    end

    assign OUT_VALID     = out_valid_r;
    assign MUX2OPU       = data_r;
    assign OUT_ROW_SHIFT = out_rs_r;
    assign OUT_COL_SHIFT = out_cs_r;
    assign OUT_LAST      = last_r;

endmodule

// File: doc/window_rot_mux.md
# window_rot_mux

Parametrised, registered window-rotation mux between the register array and the OPU. It takes a K×K window of DW-bit elements and emits it cyclically rotated by a row shift and a column shift, so the OPU can reuse one loaded window for every kernel alignment. Shifts come either from static configuration or from an internal auto-sequencer that walks all K×K alignments. Transfers use valid/ready handshakes on both sides, with one output register stage.

## Interface
- DW, 128, element width in bits
- K, 3, window edge; legal range 2..8; window holds K*K elements
- SW, derived: $clog2(K), shift-field width (not overridable)

- CLK  in  1  clock; all logic rising-edge
- RST  in  1  reset, asynchronous, active-high
- CFG_AUTO  in  1  1 = shifts taken from auto-sequencer; 0 = from CFG_ROW_SHIFT/CFG_COL_SHIFT
- CFG_ROW_SHIFT  in  SW  manual row shift; also the load value for the row counter
- CFG_COL_SHIFT  in  SW  manual column shift; also the load value for the column counter
- CFG_LOAD  in  1  single-cycle pulse: load sequencer counters from the CFG shift fields
- IN_VALID  in  1  REG_ARRAY valid
- IN_READY  out  1  block can accept a window
- REG_ARRAY  in  DW*K*K  input window; element i = r*K+c at bits [DW*(K*K-i)-1 -: DW] (element 0 at MSB)
- OUT_VALID  out  1  MUX2OPU valid
- OUT_READY  in  1  OPU accepts the output
- MUX2OPU  out  DW*K*K  rotated window, same packing as REG_ARRAY
- OUT_ROW_SHIFT  out  SW  row shift applied to the current output
- OUT_COL_SHIFT  out  SW  column shift applied to the current output
- OUT_LAST  out  1  current output is the final alignment of an auto sweep

## Operation
- Rotation: out[r][c] = in[(r+RS) mod K][(c+CS) mod K], where RS and CS are the effective shifts.
- Clamping: any shift value >= K (possible when K is not a power of 2) is treated as 0. This applies to manual shifts and to CFG_LOAD values.
- Manual mode (CFG_AUTO=0): RS/CS are the clamped CFG fields sampled in the accept cycle. Sequencer counters do not advance.
- Auto mode (CFG_AUTO=1): RS/CS are row_cnt/col_cnt. On each accept, col_cnt increments. When col_cnt = K-1, it wraps to 0 and row_cnt increments. When row_cnt = K-1, row_cnt wraps to 0.
- CFG_LOAD: next row_cnt/col_cnt take the clamped CFG values. Load wins over the increment in the same cycle. A beat accepted in that cycle still uses the pre-load counter values.
- OUT_LAST = 1 iff the beat was accepted in auto mode with RS = K-1 and CS = K-1. It is 0 for all manual beats.
- Accept condition: IN_VALID & IN_READY.
- IN_READY = !OUT_VALID | OUT_READY, combinational from OUT_READY. This gives full throughput, one beat per cycle.
- On accept, MUX2OPU, OUT_ROW_SHIFT, OUT_COL_SHIFT and OUT_LAST are registered, and OUT_VALID is set.
- When the output is consumed (OUT_READY) and no new accept occurs, OUT_VALID clears. Data registers hold their last value.
- While OUT_VALID=1 and OUT_READY=0: all output registers hold stable, IN_READY=0, and the counters hold.
- CFG_AUTO may change between beats. The mode is sampled per accept.

## Timing
- Latency: 1 cycle from accept to OUT_VALID/MUX2OPU.
- Reset (async assert, synchronous release): OUT_VALID=0, MUX2OPU=0, OUT_ROW_SHIFT=0, OUT_COL_SHIFT=0, OUT_LAST=0, row_cnt=0, col_cnt=0. IN_READY=1 while in reset.
- Reset mid-transfer discards the held output beat and restarts the sweep at (0,0).
- Simultaneous output consume and input accept: the new beat replaces the old one in the same edge, and OUT_VALID stays 1.
- There is no combinational path from REG_ARRAY to MUX2OPU.
- The only combinational in-to-out path is OUT_READY -> IN_READY.

## Test plan
- Manual rotation, DW=8, K=3, REG_ARRAY elements 0x00..0x08 in index order, RS=1, CS=1 -> one cycle later MUX2OPU = 04,05,03,07,08,06,01,02,00, OUT_ROW_SHIFT=1, OUT_COL_SHIFT=1, OUT_LAST=0.
- Clamping, K=3, CFG_ROW_SHIFT=3, CFG_COL_SHIFT=2 -> MUX2OPU = 02,00,01,05,03,04,08,06,07, OUT_ROW_SHIFT=0.
- Auto sweep from reset, 10 back-to-back beats with OUT_READY=1 -> shifts (0,0),(0,1),(0,2),(1,0)…(2,2),(0,0); OUT_LAST=1 only on beat 9; OUT_VALID high on 10 consecutive cycles.
- Backpressure: hold OUT_READY=0 for 3 cycles with IN_VALID=1 -> MUX2OPU and shifts stable, IN_READY=0, counters frozen; release -> sweep resumes at the next alignment with no skip and no duplicate.
- CFG_LOAD with CFG=(2,1) in the same cycle as an auto accept at counters (0,1) -> that beat outputs shifts (0,1); the next beat outputs (2,1); the following beat (2,2) has OUT_LAST=1.
- Assert RST mid-sweep with OUT_VALID=1 -> OUT_VALID=0 and all outputs 0 immediately (async); after release, the first auto beat uses shifts (0,0).
